// File: rtl/fifo_tx_elink_gearbox.sv
// Word FIFO feeding an e-link serialiser. Each stored word holds SYMS symbols,
// and a read sends one symbol per cycle, LSB first. Idle symbols fill any gaps.
module fifo_tx_elink_gearbox #(
    parameter int               SYM_W         = 9,
    parameter int               SYMS          = 2,
    parameter int               DEPTH         = 16,
    parameter int               PROG_FULL_THR = 12,
    parameter logic [SYM_W-1:0] IDLE_SYM      = 9'h1BC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SYMS*SYM_W-1:0]     din,
    input  logic                      wr_en,
    output logic                      full,
    output logic                      prog_full,
    output logic                      empty,
    input  logic                      rd_en,
    output logic [SYM_W:0]            dout,
    output logic                      doutRdy,
    input  logic                      fifoFLUSH,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PF_CNT   = (AW+1)'(PROG_FULL_THR);
    localparam logic [IW-1:0] LAST_IDX = IW'(SYMS - 1);

    logic [SYMS*SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [IW-1:0]         sym_idx;
    logic [SYMS*SYM_W-1:0] head;
    logic [SYM_W-1:0]      cur_sym;
    logic                  last_sym;
    logic                  do_wr;
    logic                  do_rd;
    logic                  do_pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign prog_full = (count >= PF_CNT);

    // Flush wins over both ports; a full FIFO refuses writes even if a pop frees a slot.
    assign do_wr    = wr_en && !full && !fifoFLUSH;
    assign do_rd    = rd_en && !empty && !fifoFLUSH;
    assign last_sym = (sym_idx == LAST_IDX);
    assign do_pop   = do_rd && last_sym;
    assign head     = mem[rd_ptr];

    always_comb begin
        cur_sym = head[SYM_W-1:0];
        for (int i = 1; i < SYMS; i++) begin
            if (sym_idx == IW'(i)) begin
                cur_sym = head[i*SYM_W +: SYM_W];
            end
        end
    end

    // Storage carries no reset; only control state and outputs are cleared.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sym_idx  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            doutRdy  <= 1'b0;
            dout     <= {1'b0, IDLE_SYM};
        end else if (fifoFLUSH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sym_idx  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            doutRdy  <= 1'b0;
            dout     <= {1'b0, IDLE_SYM};
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (do_rd) begin
                dout    <= {last_sym, cur_sym};
                doutRdy <= 1'b1;
                sym_idx <= last_sym ? '0 : sym_idx + 1'b1;
                if (last_sym) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end else begin
                dout    <= {1'b0, IDLE_SYM};
                doutRdy <= 1'b0;
            end
            case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx_elink_gearbox.sv
// Bench for fifo_tx_elink_gearbox: fixed vectors, directed corner sequences and
// random traffic compared against a symbol-queue model of the FIFO.
module tb_fifo_tx_elink_gearbox;

    localparam int               SYM_W         = 9;
    localparam int               SYMS          = 2;
    localparam int               DEPTH         = 16;
    localparam int               PROG_FULL_THR = 12;
    localparam logic [SYM_W-1:0] IDLE_SYM      = 9'h1BC;
    localparam int               DW            = SYMS*SYM_W;
    localparam int               CW            = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [DW-1:0] din       = '0;
    logic          wr_en     = 1'b0;
    logic          rd_en     = 1'b0;
    logic          fifoFLUSH = 1'b0;
    logic          full;
    logic          prog_full;
    logic          empty;
    logic          overflow;
    logic          doutRdy;
    logic [SYM_W:0] dout;
    logic [CW-1:0]  count;

    int tests = 0;
    int fails = 0;

    // Model: every stored symbol tagged with its last flag, in transmit order.
    logic [SYM_W:0] sym_q[$];
    logic           m_ovf  = 1'b0;
    logic [SYM_W:0] m_dout = {1'b0, IDLE_SYM};
    logic           m_rdy  = 1'b0;

    typedef struct {
        logic           fl;
        logic           wr;
        logic           rd;
        logic [DW-1:0]  d;
        logic [SYM_W:0] e_dout;
        logic           e_rdy;
        int             e_count;
        logic           e_empty;
        logic           e_ovf;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    fifo_tx_elink_gearbox #(
        .SYM_W(SYM_W), .SYMS(SYMS), .DEPTH(DEPTH),
        .PROG_FULL_THR(PROG_FULL_THR), .IDLE_SYM(IDLE_SYM)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en),
        .full(full), .prog_full(prog_full), .empty(empty),
        .rd_en(rd_en), .dout(dout), .doutRdy(doutRdy),
        .fifoFLUSH(fifoFLUSH), .overflow(overflow), .count(count)
    );

    function automatic int m_words();
        return (sym_q.size() + SYMS - 1) / SYMS;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic fl, input logic wr, input logic rd, input logic [DW-1:0] d);
        int words;
        words = m_words();
        if (fl) begin
            sym_q.delete();
            m_ovf  = 1'b0;
            m_dout = {1'b0, IDLE_SYM};
            m_rdy  = 1'b0;
        end else begin
            if (rd && sym_q.size() > 0) begin
                m_dout = sym_q.pop_front();
                m_rdy  = 1'b1;
            end else begin
                m_dout = {1'b0, IDLE_SYM};
                m_rdy  = 1'b0;
            end
            if (wr) begin
                if (words == DEPTH) m_ovf = 1'b1;
                else for (int i = 0; i < SYMS; i++) sym_q.push_back({(i == SYMS-1), d[i*SYM_W +: SYM_W]});
            end
        end
    endtask

    task automatic model_reset();
        sym_q.delete();
        m_ovf  = 1'b0;
        m_dout = {1'b0, IDLE_SYM};
        m_rdy  = 1'b0;
    endtask

    task automatic applyStimulus(input logic fl, input logic wr, input logic rd, input logic [DW-1:0] d);
        fifoFLUSH = fl;
        wr_en     = wr;
        rd_en     = rd;
        din       = d;
        model_step(fl, wr, rd, d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        int words;
        words = m_words();
        checkOutput("dout",      32'(dout),      32'(m_dout));
        checkOutput("doutRdy",   32'(doutRdy),   32'(m_rdy));
        checkOutput("count",     32'(count),     32'(words));
        checkOutput("empty",     32'(empty),     32'(words == 0));
        checkOutput("full",      32'(full),      32'(words == DEPTH));
        checkOutput("prog_full", 32'(prog_full), 32'(words >= PROG_FULL_THR));
        checkOutput("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_dout"},     32'(dout),      32'({1'b0, IDLE_SYM}));
        checkOutput({tag, "_doutRdy"},  32'(doutRdy),   32'(0));
        checkOutput({tag, "_count"},    32'(count),     32'(0));
        checkOutput({tag, "_empty"},    32'(empty),     32'(1));
        checkOutput({tag, "_full"},     32'(full),      32'(0));
        checkOutput({tag, "_prog_full"},32'(prog_full), 32'(0));
        checkOutput({tag, "_overflow"}, 32'(overflow),  32'(0));
    endtask

    initial begin
        // fl, wr, rd, din, dout, doutRdy, count, empty, overflow
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 18'h3_FF01, 10'h1BC, 1'b0, 1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 18'h0_0000, 10'h101, 1'b1, 1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 18'h0_0000, 10'h3FF, 1'b1, 0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 18'h0_0000, 10'h1BC, 1'b0, 0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 18'h2_4C33, 10'h1BC, 1'b0, 1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 18'h1_2345, 10'h1BC, 1'b0, 2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 18'h0_0000, 10'h033, 1'b1, 2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 18'h3_FFFF, 10'h1BC, 1'b0, 0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 18'h0_0000, 10'h1BC, 1'b0, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 18'h0_0077, 10'h1BC, 1'b0, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 18'h0_0000, 10'h077, 1'b1, 1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 18'h0_0000, 10'h200, 1'b1, 0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].fl, vecs[v].wr, vecs[v].rd, vecs[v].d);
            checkOutput($sformatf("vec%0d_dout", v),     32'(dout),    32'(vecs[v].e_dout));
            checkOutput($sformatf("vec%0d_doutRdy", v),  32'(doutRdy), 32'(vecs[v].e_rdy));
            checkOutput($sformatf("vec%0d_count", v),    32'(count),   32'(vecs[v].e_count));
            checkOutput($sformatf("vec%0d_empty", v),    32'(empty),   32'(vecs[v].e_empty));
            checkOutput($sformatf("vec%0d_overflow", v), 32'(overflow),32'(vecs[v].e_ovf));
        end
        model_reset();

        // Fill past capacity: writes 17 and 18 must be dropped and flagged.
        for (int n = 1; n <= 18; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, DW'($urandom));
            check_model();
            if (n == 15) checkOutput("full_before_16th", 32'(full), 32'(0));
            if (n == 16) checkOutput("full_at_16th", 32'(full), 32'(1));
            if (n == 11) checkOutput("prog_full_at_11", 32'(prog_full), 32'(0));
            if (n == 12) checkOutput("prog_full_at_12", 32'(prog_full), 32'(1));
        end
        checkOutput("overflow_after_18", 32'(overflow), 32'(1));
        checkOutput("count_after_18",    32'(count),    32'(16));

        // Asynchronous reset in the middle of a partially sent word.
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        check_model();
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, 18'h0_0055);
        check_model();
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        check_model();
        checkOutput("first_after_reset", 32'(dout), 32'(10'h055));
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        check_model();

        // Continuous reads with a write every other cycle, long enough to wrap pointers twice.
        for (int w = 0; w < 40; w++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, DW'($urandom));
            check_model();
            if (w > 0) checkOutput("stream_rdy_a", 32'(doutRdy), 32'(1));
            checkOutput("stream_count_a", 32'(count <= 1), 32'(1));
            applyStimulus(1'b0, 1'b0, 1'b1, '0);
            check_model();
            checkOutput("stream_rdy_b", 32'(doutRdy), 32'(1));
            checkOutput("stream_last_b", 32'(dout[SYM_W]), 32'(0));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        check_model();
        checkOutput("stream_tail_last", 32'(dout[SYM_W]), 32'(1));

        // Random traffic alternating between write-heavy and read-heavy phases.
        for (int blk = 0; blk < 10; blk++) begin
            int wr_pct;
            wr_pct = (blk % 2 == 0) ? 85 : 25;
            for (int c = 0; c < 100; c++) begin
                logic fl, wr, rd;
                fl = ($urandom_range(0, 99) == 0);
                wr = ($urandom_range(0, 99) < wr_pct);
                rd = ($urandom_range(0, 99) < 55);
                applyStimulus(fl, wr, rd, DW'($urandom));
                check_model();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
